// File: rtl/seq_mult_if.sv
// Start/done handshake and operand/result bus for the sequential multiplier.
//   start    : one-cycle request pulse (master -> slave)
//   plicand  : multiplicand, WIDTH bits (master -> slave)
//   pliar    : multiplier, WIDTH bits (master -> slave)
//   busy     : operation in progress (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   product  : 2*WIDTH-bit result, held until the next done (slave -> master)
//   sign     : result negative, held with product (slave -> master)
interface seq_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     plicand;
    logic [WIDTH-1:0]     pliar;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 sign;

    modport master (
        output start, plicand, pliar,
        input  busy, done, product, sign
    );

    modport slave (
        input  start, plicand, pliar,
        output busy, done, product, sign
    );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier with start/done handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : seq_mult_if slave (start, plicand, pliar in; busy, done, product, sign out)
// Parameters:
//   WIDTH    : operand width, product is 2*WIDTH bits (WIDTH >= 2)
//   SIGNED   : 1 = two's-complement operands, 0 = unsigned operands
//   OUT_MODE : 0 = product is magnitude with separate sign, 1 = two's-complement product
// Flow: IDLE -> LOAD -> RUN (WIDTH cycles) -> DONE -> IDLE. done rises WIDTH+2
// cycles after the edge that accepted start; start outside IDLE is ignored.
module seq_mult_param #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          OUT_MODE = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    seq_mult_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic             busy_r;
    logic             done_r;
    logic [PW-1:0]    product_r;
    logic             sign_r;

    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic             neg_c;
    logic [PW-1:0]    addend_c;
    logic [PW-1:0]    result_c;

    // Operand magnitudes; the W-bit unsigned view of -2^(W-1) is already its magnitude.
    always_comb begin
        abs_a_c = op_a;
        abs_b_c = op_b;
        neg_c   = 1'b0;
        if (SIGNED) begin
            if (op_a[WIDTH-1]) abs_a_c = WIDTH'(~op_a + WIDTH'(1));
            if (op_b[WIDTH-1]) abs_b_c = WIDTH'(~op_b + WIDTH'(1));
            neg_c = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end
    end

    // Partial product for the current bit position (cnt counts WIDTH down to 1).
    always_comb begin
        addend_c = PW'(mag_a) << (CW'(WIDTH) - cnt);
    end

    // Final result formatting.
    always_comb begin
        result_c = acc;
        if (OUT_MODE && neg) result_c = PW'(~acc + PW'(1));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
            sign_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.plicand;
                        op_b   <= bus.pliar;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    mag_a <= abs_a_c;
                    mag_b <= abs_b_c;
                    neg   <= neg_c;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH);
                    state <= RUN;
                end
                RUN: begin
                    if (mag_b[0]) acc <= acc + addend_c;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    done_r    <= 1'b1;
                    product_r <= result_c;
                    // A zero result is never reported as negative.
                    sign_r    <= neg & (|acc);
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.sign    = sign_r;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: three 8-bit instances (signed/magnitude, signed/two's
// complement, unsigned) run the same operands side by side; a 16-bit unsigned
// instance covers the wide case. Expected results are queued at start and popped at done.
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mult_if #(.WIDTH(8))  if0 (), if1 (), if2 ();
    seq_mult_if #(.WIDTH(16)) if3 ();

    seq_mult_param #(.WIDTH(8),  .SIGNED(1'b1), .OUT_MODE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_mult_param #(.WIDTH(8),  .SIGNED(1'b1), .OUT_MODE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_mult_param #(.WIDTH(8),  .SIGNED(1'b0), .OUT_MODE(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seq_mult_param #(.WIDTH(16), .SIGNED(1'b0), .OUT_MODE(1'b0)) u3 (.clk(clk), .rst(rst), .bus(if3));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] q2[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {sign, product} for an 8-bit operation, from integer arithmetic.
    function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input bit sgn, input bit om);
        int ia, ib, p, m;
        logic [15:0] prod;
        if (sgn) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({24'd0, a});
            ib = int'({24'd0, b});
        end
        p = ia * ib;
        m = (p < 0) ? -p : p;
        if (om) prod = 16'(p);
        else    prod = 16'(m);
        return {(p < 0), prod};
    endfunction

    task automatic drive8(input logic st, input logic [7:0] a, input logic [7:0] b);
        if0.start = st; if0.plicand = a; if0.pliar = b;
        if1.start = st; if1.plicand = a; if1.pliar = b;
        if2.start = st; if2.plicand = a; if2.pliar = b;
    endtask

    // One 8-bit operation on u0..u2. inject_at: cycle to pulse a rejected start
    // (-1 none); rst_at: cycle to assert reset mid-operation (-1 none).
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int inject_at, input int rst_at);
        int lat, busy_cnt, extra_done;
        bit seen;
        logic [16:0] e0, e1, e2;
        @(negedge clk);
        drive8(1'b1, a, b);
        q0.push_back(model8(a, b, 1'b1, 1'b0));
        q1.push_back(model8(a, b, 1'b1, 1'b1));
        q2.push_back(model8(a, b, 1'b0, 1'b0));
        @(negedge clk);
        // Operands change after capture; the running operation must not see it.
        drive8(1'b0, ~a, b ^ 8'h5A);
        lat = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            if (if0.busy) busy_cnt++;
            if (lat == inject_at) drive8(1'b1, 8'h11, 8'h22);
            else                  drive8(1'b0, 8'h11, 8'h22);
            if (lat == rst_at) begin
                rst = 1'b0;
                #1;
                chk({tag, "_rst_outs"}, 64'({if0.busy, if0.done, if0.sign, if0.product}), 64'd0);
                void'(q0.pop_front());
                void'(q1.pop_front());
                void'(q2.pop_front());
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
            if (if0.done) seen = 1'b1;
        end
        drive8(1'b0, 8'h00, 8'h00);
        chk({tag, "_latency"}, 64'(lat), 64'd10);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd10);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        chk({tag, "_u0"}, 64'({if0.done, if0.sign, if0.product}), 64'({1'b1, e0}));
        chk({tag, "_u1"}, 64'({if1.done, if1.sign, if1.product}), 64'({1'b1, e1}));
        chk({tag, "_u2"}, 64'({if2.done, if2.sign, if2.product}), 64'({1'b1, e2}));
        extra_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (if0.done) extra_done++;
        end
        chk({tag, "_extra_done"}, 64'(extra_done), 64'd0);
        chk({tag, "_held"}, 64'({if0.busy, if0.sign, if0.product}), 64'({1'b0, e0}));
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b);
        int lat;
        bit seen;
        logic [31:0] exp;
        exp = 32'(64'(a) * 64'(b));
        @(negedge clk);
        if3.start = 1'b1; if3.plicand = a; if3.pliar = b;
        @(negedge clk);
        if3.start = 1'b0; if3.plicand = '0; if3.pliar = '0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (if3.done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd18);
        chk({tag, "_result"}, 64'({if3.sign, if3.product}), 64'({1'b0, exp}));
    endtask

    initial begin
        rst = 1'b1;
        drive8(1'b0, 8'h00, 8'h00);
        if3.start = 1'b0; if3.plicand = '0; if3.pliar = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_u0", 64'({if0.busy, if0.done, if0.sign, if0.product}), 64'd0);
        chk("reset_u3", 64'({if3.busy, if3.done, if3.sign, if3.product}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run8("3x5",       8'h03, 8'h05, -1, -1);
        run8("m7x6",      8'hF9, 8'h06, -1, -1);
        chk("m7x6_u0_lit", 64'({if0.sign, if0.product}), 64'({1'b1, 16'd42}));
        chk("m7x6_u1_lit", 64'({if1.sign, if1.product}), 64'({1'b1, 16'hFFD6}));
        run8("m128xm128", 8'h80, 8'h80, -1, -1);
        chk("m128_u0_lit", 64'({if0.sign, if0.product}), 64'({1'b0, 16'd16384}));
        run8("0xm5",      8'h00, 8'hFB, -1, -1);
        chk("zero_u1_lit", 64'({if1.sign, if1.product}), 64'd0);
        run8("ffxff",     8'hFF, 8'hFF, -1, -1);
        chk("ffxff_u2_lit", 64'({if2.sign, if2.product}), 64'({1'b0, 16'hFE01}));
        run8("7x9_inject", 8'h07, 8'h09, 4, -1);
        run8("abort",     8'h55, 8'h0C, -1, 5);
        run8("post_rst",  8'h7F, 8'h81, -1, -1);
        run8("m1x7f",     8'hFF, 8'h7F, -1, -1);

        run16("w16_ffff", 16'hFFFF, 16'hFFFF);
        chk("w16_lit", 64'(if3.product), 64'h0000_0000_FFFE_0001);
        run16("w16_mix",  16'h1234, 16'h0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
